// File: rtl/mem_arbiter.sv
// Three-way arbiter (loader > data > fetch) in front of one single-ported memory.
// Each access is registered, held until mem_ready or watchdog abort, then acked for one cycle.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic              f_err,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_ack,
    output logic              l_err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
    typedef enum logic [1:0] {OwnNone, OwnF, OwnD, OwnL} owner_e;

    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

    state_e     state;
    owner_e     owner;
    logic [7:0] watchdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            owner     <= OwnNone;
            watchdog  <= 8'd0;
            f_ack     <= 1'b0;
            f_err     <= 1'b0;
            f_rdata   <= 32'h0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'h0;
            l_ack     <= 1'b0;
            l_err     <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end else begin
            // Acks and errors are single-cycle; rdata holds between acks.
            f_ack <= 1'b0;
            f_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            l_ack <= 1'b0;
            l_err <= 1'b0;

            case (state)
                StIdle: begin
                    watchdog <= 8'd0;
                    if (l_req) begin
                        owner     <= OwnL;
                        state     <= StBusy;
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= l_addr;
                        mem_wdata <= l_wdata;
                        mem_wstrb <= 4'hF;
                    end else if (d_req) begin
                        owner     <= OwnD;
                        state     <= StBusy;
                        mem_valid <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : 4'h0;
                    end else if (f_req) begin
                        owner <= OwnF;
                        if (f_addr[1:0] != 2'b00) begin
                            // Misaligned fetch never reaches memory.
                            state   <= StResp;
                            f_ack   <= 1'b1;
                            f_err   <= 1'b1;
                            f_rdata <= 32'h0;
                        end else begin
                            state     <= StBusy;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= f_addr;
                            mem_wdata <= 32'h0;
                            mem_wstrb <= 4'h0;
                        end
                    end
                end
                StBusy: begin
                    // A late mem_ready in the final watchdog cycle still completes normally.
                    if (mem_ready || watchdog == WdLast) begin
                        mem_valid <= 1'b0;
                        state     <= StResp;
                        case (owner)
                            OwnF: begin
                                f_ack   <= 1'b1;
                                f_err   <= !mem_ready;
                                f_rdata <= mem_ready ? mem_rdata : 32'h0;
                            end
                            OwnD: begin
                                d_ack   <= 1'b1;
                                d_err   <= !mem_ready;
                                d_rdata <= (mem_ready && !mem_we) ? mem_rdata : 32'h0;
                            end
                            OwnL: begin
                                l_ack <= 1'b1;
                                l_err <= !mem_ready;
                            end
                            default: ;
                        endcase
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end
                StResp: begin
                    state <= StIdle;
                    owner <= OwnNone;
                end
                default: begin
                    state <= StIdle;
                    owner <= OwnNone;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks with a queue of expected acks
// and a small latency-programmable memory responder.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic              clk;
    logic              rst_n;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic              f_err;
    logic [31:0]       f_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_ack;
    logic              d_err;
    logic [31:0]       d_rdata;
    logic              l_req;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_ack;
    logic              l_err;
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .f_err    (f_err),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_ack    (d_ack),
        .d_err    (d_err),
        .d_rdata  (d_rdata),
        .l_req    (l_req),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_ack    (l_ack),
        .l_err    (l_err),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ready after wait_cycles of mem_valid, or never.
    logic [31:0] mem_model [256];
    logic [7:0]  busy_cnt;
    int          wait_cycles;
    bit          never;
    bit          force_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 8'd0;
        else        busy_cnt <= mem_valid ? busy_cnt + 8'd1 : 8'd0;
    end

    assign mem_ready = force_ready | (mem_valid && !never && int'(busy_cnt) >= wait_cycles);
    assign mem_rdata = mem_valid ? mem_model[mem_addr[9:2]] : 32'hBAD0BAD0;

    typedef struct packed {
        logic [2:0]  acks;  // {l, d, f}
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    function automatic logic obs_err();
        if (l_ack) return l_err;
        if (d_ack) return d_err;
        return f_err;
    endfunction

    function automatic logic [31:0] obs_rdata();
        if (d_ack) return d_rdata;
        if (f_ack) return f_rdata;
        return 32'h0;
    endfunction

    task automatic wait_ack(input int budget, output int lat, output int vcnt, output bit got);
        got  = 1'b0;
        lat  = 0;
        vcnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (mem_valid) vcnt++;
            if (l_ack | d_ack | f_ack) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        f_req       = 1'b0;
        f_addr      = '0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_addr      = '0;
        d_wdata     = 32'h0;
        d_wstrb     = 4'h0;
        l_req       = 1'b0;
        l_addr      = '0;
        l_wdata     = 32'h0;
        wait_cycles = 0;
        never       = 1'b0;
        force_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        #2;
        checks++;
        if ({mem_valid, mem_we, mem_wstrb, f_ack, d_ack, l_ack, f_err, d_err, l_err} !== 13'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b we=%b strb=%h acks=%b%b%b errs=%b%b%b, want all 0",
                     mem_valid, mem_we, mem_wstrb, l_ack, d_ack, f_ack, l_err, d_err, f_err);
        end
        checks++;
        if ({f_rdata, d_rdata, mem_wdata} !== 96'h0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_data: got f_rdata=%h d_rdata=%h wdata=%h addr=%h, want 0",
                     f_rdata, d_rdata, mem_wdata, mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        int   lat, vcnt;
        bit   got;
        exp_t e;
        mem_model[8'h04] = 32'h00500093;
        wait_cycles = 1;
        f_addr = 32'h10;
        f_req  = 1'b1;
        sb.push_back('{acks: 3'b001, err: 1'b0, rdata: 32'h00500093});
        @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL read_cycle1: got valid=%b we=%b addr=%h strb=%h, want 1 0 00000010 0",
                     mem_valid, mem_we, mem_addr, mem_wstrb);
        end
        f_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b1 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_cycle2: got valid=%b ready=%b, want 1 1", mem_valid, mem_ready);
        end
        wait_ack(6, lat, vcnt, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != 1 || {l_ack, d_ack, f_ack} !== e.acks || obs_err() !== e.err
            || obs_rdata() !== e.rdata || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: got=%0d lat=%0d acks=%b err=%b rdata=%h valid=%b, want lat=1 acks=%b err=%b rdata=%h valid=0",
                     got, lat, {l_ack, d_ack, f_ack}, obs_err(), obs_rdata(), mem_valid,
                     e.acks, e.err, e.rdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (f_ack !== 1'b0 || f_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL read_pulse: got f_ack=%b f_rdata=%h, want 0 00500093", f_ack, f_rdata);
        end
    endtask

    task automatic test_misaligned();
        int   lat, vcnt;
        bit   got;
        exp_t e;
        f_addr = 32'h6;
        f_req  = 1'b1;
        sb.push_back('{acks: 3'b001, err: 1'b1, rdata: 32'h0});
        wait_ack(6, lat, vcnt, got);
        f_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got || lat > 2 || vcnt != 0 || {l_ack, d_ack, f_ack} !== e.acks
            || obs_err() !== e.err || obs_rdata() !== e.rdata) begin
            errors++;
            $display("FAIL misaligned: got=%0d lat=%0d valid_cycles=%0d acks=%b err=%b rdata=%h, want lat<=2 valid_cycles=0 acks=%b err=%b rdata=%h",
                     got, lat, vcnt, {l_ack, d_ack, f_ack}, obs_err(), obs_rdata(),
                     e.acks, e.err, e.rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_priority();
        logic [3:0] exp_strb [3];
        exp_t       e;
        bit         got, seen;
        int         t, last;
        exp_strb = '{4'hF, 4'h0, 4'h0};
        mem_model[8'h40] = 32'hCAFE0001;
        mem_model[8'h00] = 32'h13579BDF;
        wait_cycles = 0;
        l_addr  = 32'h0;
        l_wdata = 32'hDEADBEEF;
        d_addr  = 32'h100;
        d_we    = 1'b0;
        f_addr  = 32'h0;
        l_req = 1'b1;
        d_req = 1'b1;
        f_req = 1'b1;
        sb.push_back('{acks: 3'b100, err: 1'b0, rdata: 32'h0});
        sb.push_back('{acks: 3'b010, err: 1'b0, rdata: 32'hCAFE0001});
        sb.push_back('{acks: 3'b001, err: 1'b0, rdata: 32'h13579BDF});
        t    = 0;
        last = 0;
        for (int g = 0; g < 3; g++) begin
            got  = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(posedge clk);
                #1;
                t++;
                if (mem_valid && !seen) begin
                    seen = 1'b1;
                    checks++;
                    if (mem_wstrb !== exp_strb[g]) begin
                        errors++;
                        $display("FAIL prio_strb%0d: got %h, want %h", g, mem_wstrb, exp_strb[g]);
                    end
                end
                if (l_ack | d_ack | f_ack) got = 1'b1;
            end
            e = sb.pop_front();
            checks++;
            if (!got || {l_ack, d_ack, f_ack} !== e.acks || obs_err() !== e.err
                || obs_rdata() !== e.rdata) begin
                errors++;
                $display("FAIL prio_ack%0d: got=%0d acks=%b err=%b rdata=%h, want acks=%b err=%b rdata=%h",
                         g, got, {l_ack, d_ack, f_ack}, obs_err(), obs_rdata(),
                         e.acks, e.err, e.rdata);
            end
            if (g > 0) begin
                checks++;
                if (t - last != 3) begin
                    errors++;
                    $display("FAIL prio_spacing%0d: got %0d cycles, want 3", g, t - last);
                end
            end
            last = t;
            if (e.acks[2]) l_req = 1'b0;
            if (e.acks[1]) d_req = 1'b0;
            if (e.acks[0]) f_req = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_strobes();
        int   lat, vcnt;
        bit   got;
        exp_t e;
        wait_cycles = 1;
        d_we    = 1'b1;
        d_addr  = 32'h204;
        d_wstrb = 4'b0011;
        d_wdata = 32'h1234ABCD;
        d_req   = 1'b1;
        sb.push_back('{acks: 3'b010, err: 1'b0, rdata: 32'h0});
        @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0011
            || mem_wdata !== 32'h1234ABCD || mem_addr !== 32'h204) begin
            errors++;
            $display("FAIL store_port: got valid=%b we=%b strb=%h wdata=%h addr=%h, want 1 1 3 1234abcd 00000204",
                     mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr);
        end
        d_req = 1'b0;
        wait_ack(6, lat, vcnt, got);
        e = sb.pop_front();
        checks++;
        if (!got || {l_ack, d_ack, f_ack} !== e.acks || obs_err() !== e.err
            || obs_rdata() !== e.rdata) begin
            errors++;
            $display("FAIL store_ack: got=%0d acks=%b err=%b rdata=%h, want acks=%b err=%b rdata=%h",
                     got, {l_ack, d_ack, f_ack}, obs_err(), obs_rdata(), e.acks, e.err, e.rdata);
        end
        d_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int   lat, vcnt;
        bit   got;
        exp_t e;
        // Never-ready load aborts after TIMEOUT busy cycles.
        never  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h100;
        d_req  = 1'b1;
        sb.push_back('{acks: 3'b010, err: 1'b1, rdata: 32'h0});
        wait_ack(TIMEOUT + 4, lat, vcnt, got);
        d_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got || vcnt != TIMEOUT || {l_ack, d_ack, f_ack} !== e.acks
            || obs_err() !== e.err || obs_rdata() !== e.rdata) begin
            errors++;
            $display("FAIL timeout_abort: got=%0d valid_cycles=%0d acks=%b err=%b rdata=%h, want valid_cycles=%0d acks=%b err=%b rdata=%h",
                     got, vcnt, {l_ack, d_ack, f_ack}, obs_err(), obs_rdata(),
                     TIMEOUT, e.acks, e.err, e.rdata);
        end
        @(posedge clk);
        #1;
        // Ready in the final busy cycle wins over the abort.
        never       = 1'b0;
        wait_cycles = TIMEOUT - 1;
        d_req       = 1'b1;
        sb.push_back('{acks: 3'b010, err: 1'b0, rdata: 32'hCAFE0001});
        wait_ack(TIMEOUT + 4, lat, vcnt, got);
        d_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got || vcnt != TIMEOUT || {l_ack, d_ack, f_ack} !== e.acks
            || obs_err() !== e.err || obs_rdata() !== e.rdata) begin
            errors++;
            $display("FAIL timeout_late_ready: got=%0d valid_cycles=%0d acks=%b err=%b rdata=%h, want valid_cycles=%0d acks=%b err=%b rdata=%h",
                     got, vcnt, {l_ack, d_ack, f_ack}, obs_err(), obs_rdata(),
                     TIMEOUT, e.acks, e.err, e.rdata);
        end
        wait_cycles = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ready_idle();
        bit stray;
        stray       = 1'b0;
        force_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (mem_valid | f_ack | d_ack | l_ack) stray = 1'b1;
        end
        force_ready = 1'b0;
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL ready_idle: got activity=%b, want 0", stray);
        end
    endtask

    task automatic test_reset_mid_access();
        int   lat, vcnt;
        bit   got;
        exp_t e;
        never  = 1'b1;
        f_addr = 32'h10;
        f_req  = 1'b1;
        @(posedge clk);
        #1;
        f_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || {l_ack, d_ack, f_ack} !== 3'b000 || f_rdata !== 32'h0
            || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b acks=%b f_rdata=%h d_rdata=%h, want all 0",
                     mem_valid, {l_ack, d_ack, f_ack}, f_rdata, d_rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        never = 1'b0;
        @(posedge clk);
        #1;
        f_req = 1'b1;
        sb.push_back('{acks: 3'b001, err: 1'b0, rdata: 32'h00500093});
        wait_ack(8, lat, vcnt, got);
        f_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got || vcnt != 1 || {l_ack, d_ack, f_ack} !== e.acks || obs_err() !== e.err
            || obs_rdata() !== e.rdata) begin
            errors++;
            $display("FAIL reset_recover: got=%0d valid_cycles=%0d acks=%b err=%b rdata=%h, want valid_cycles=1 acks=%b err=%b rdata=%h",
                     got, vcnt, {l_ack, d_ack, f_ack}, obs_err(), obs_rdata(),
                     e.acks, e.err, e.rdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_read();
        test_misaligned();
        test_priority();
        test_store_strobes();
        test_timeout();
        test_ready_idle();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
